// File: rtl/pe_net_if.sv
// PE-side NoC interface: FWFT TX and RX FIFOs between a processing element and one H-tree port.
// Optional macro PE_IF_ADDR_CHECK_EN drops RX flits not addressed to MyAddr and counts them.
module pe_net_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 3,
    parameter int MyAddr    = 0,
    parameter int FifoDepth = 4
) (
    input  logic                           i_sclk,
    input  logic                           i_reset,
    input  logic [DataWidth-1:0]           i_tx_data,
    input  logic [AddrWidth-1:0]           i_tx_dest,
    input  logic                           i_tx_valid,
    output logic                           o_tx_ready,
    output logic [DataWidth+AddrWidth-1:0] o_noc_data,
    output logic                           o_noc_valid,
    input  logic                           i_noc_ready,
    input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
    input  logic                           i_noc_valid,
    output logic                           o_noc_ready,
    output logic [DataWidth-1:0]           o_rx_data,
    output logic                           o_rx_valid,
    input  logic                           i_rx_ready,
    output logic [15:0]                    o_drop_count
);

    localparam int FlitWidth = DataWidth + AddrWidth;
    localparam int IdxWidth  = $clog2(FifoDepth);
    localparam int PtrWidth  = IdxWidth + 1;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return p + PtrWidth'(1);
    endfunction

    function automatic logic ptr_full(input logic [PtrWidth-1:0] wr, input logic [PtrWidth-1:0] rd);
        return (wr[PtrWidth-1] != rd[PtrWidth-1]) && (wr[IdxWidth-1:0] == rd[IdxWidth-1:0]);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // TX path: PE -> NoC
    logic [FlitWidth-1:0] tx_mem [FifoDepth];
    logic [PtrWidth-1:0]  tx_wr_ptr;
    logic [PtrWidth-1:0]  tx_rd_ptr;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 tx_push;
    logic                 tx_pop;

    assign tx_full     = ptr_full(tx_wr_ptr, tx_rd_ptr);
    assign tx_empty    = (tx_wr_ptr == tx_rd_ptr);
    assign tx_push     = i_tx_valid && !tx_full;
    assign tx_pop      = !tx_empty && i_noc_ready;
    assign o_tx_ready  = !tx_full;
    assign o_noc_valid = !tx_empty;
    // Head is masked while empty so data outputs read zero out of reset.
    assign o_noc_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr[IdxWidth-1:0]];

    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= ptr_inc(tx_wr_ptr);
            if (tx_pop)  tx_rd_ptr <= ptr_inc(tx_rd_ptr);
        end
    end

    always_ff @(posedge i_sclk) begin
        if (tx_push) tx_mem[tx_wr_ptr[IdxWidth-1:0]] <= {i_tx_dest, i_tx_data};
    end

    // RX path: NoC -> PE
    logic [DataWidth-1:0] rx_mem [FifoDepth];
    logic [PtrWidth-1:0]  rx_wr_ptr;
    logic [PtrWidth-1:0]  rx_rd_ptr;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 rx_accept;
    logic                 rx_addr_ok;
    logic                 rx_push;
    logic                 rx_pop;

    assign rx_full     = ptr_full(rx_wr_ptr, rx_rd_ptr);
    assign rx_empty    = (rx_wr_ptr == rx_rd_ptr);
    assign rx_accept   = i_noc_valid && !rx_full;
    assign rx_push     = rx_accept && rx_addr_ok;
    assign rx_pop      = !rx_empty && i_rx_ready;
    assign o_noc_ready = !rx_full;
    assign o_rx_valid  = !rx_empty;
    assign o_rx_data   = rx_empty ? '0 : rx_mem[rx_rd_ptr[IdxWidth-1:0]];

`ifdef PE_IF_ADDR_CHECK_EN
    localparam logic [AddrWidth-1:0] MyAddrVec = AddrWidth'(MyAddr);
    logic [15:0] drop_count;

    // Misrouted flits are still handshaken so the NoC never stalls on them.
    assign rx_addr_ok   = (i_noc_data[FlitWidth-1:DataWidth] == MyAddrVec);
    assign o_drop_count = drop_count;

    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            drop_count <= '0;
        end else if (rx_accept && !rx_addr_ok) begin
            drop_count <= sat_inc16(drop_count);
        end
    end
`else
    logic unused_rx_addr;

    assign rx_addr_ok     = 1'b1;
    assign o_drop_count   = '0;
    assign unused_rx_addr = ^{i_noc_data[FlitWidth-1:DataWidth], AddrWidth'(MyAddr), sat_inc16(16'd0)};
`endif

    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= ptr_inc(rx_wr_ptr);
            if (rx_pop)  rx_rd_ptr <= ptr_inc(rx_rd_ptr);
        end
    end

    always_ff @(posedge i_sclk) begin
        if (rx_push) rx_mem[rx_wr_ptr[IdxWidth-1:0]] <= i_noc_data[DataWidth-1:0];
    end

endmodule

// File: tb/tb_pe_net_if.sv
// Scoreboard bench for pe_net_if: queue-based reference model of both FIFO paths with random and directed traffic.
module tb_pe_net_if;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int MY = 2;
    localparam int D  = 4;
    localparam int FW = DW + AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] tx_data;
    logic [AW-1:0] tx_dest;
    logic          tx_valid;
    logic          tx_ready;
    logic [FW-1:0] noc_out_data;
    logic          noc_out_valid;
    logic          noc_out_ready;
    logic [FW-1:0] noc_in_data;
    logic          noc_in_valid;
    logic          noc_in_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    pe_net_if #(.DataWidth(DW), .AddrWidth(AW), .MyAddr(MY), .FifoDepth(D)) dut (
        .i_sclk      (clk),
        .i_reset     (rst_n),
        .i_tx_data   (tx_data),
        .i_tx_dest   (tx_dest),
        .i_tx_valid  (tx_valid),
        .o_tx_ready  (tx_ready),
        .o_noc_data  (noc_out_data),
        .o_noc_valid (noc_out_valid),
        .i_noc_ready (noc_out_ready),
        .i_noc_data  (noc_in_data),
        .i_noc_valid (noc_in_valid),
        .o_noc_ready (noc_in_ready),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .i_rx_ready  (rx_ready),
        .o_drop_count(drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [FW-1:0] txq[$];
    logic [DW-1:0] rxq[$];
    int            exp_drops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX monitor/model: queue length is the FIFO occupancy, head is the expected flit.
    always @(negedge clk) begin
        bit do_pop;
        bit do_push;
        if (!rst_n) begin
            txq.delete();
            check("rst_tx_ready", tx_ready, 1);
            check("rst_noc_valid", noc_out_valid, 0);
            check("rst_noc_data", noc_out_data, 0);
        end else begin
            check("tx_ready", tx_ready, txq.size() < D);
            check("noc_valid", noc_out_valid, txq.size() != 0);
            if (txq.size() != 0) check("noc_data", noc_out_data, txq[0]);
            do_pop  = (txq.size() != 0) && noc_out_ready;
            do_push = tx_valid && (txq.size() < D);
            if (do_pop) void'(txq.pop_front());
            if (do_push) txq.push_back({tx_dest, tx_data});
        end
    end

    // RX monitor/model: only flits for this PE reach the queue when address checking is built in.
    always @(negedge clk) begin
        bit do_pop;
        bit do_acc;
        bit addr_ok;
        if (!rst_n) begin
            rxq.delete();
            exp_drops = 0;
            check("rst_noc_ready", noc_in_ready, 1);
            check("rst_rx_valid", rx_valid, 0);
            check("rst_rx_data", rx_data, 0);
            check("rst_drop_count", drop_count, 0);
        end else begin
            check("noc_ready", noc_in_ready, rxq.size() < D);
            check("rx_valid", rx_valid, rxq.size() != 0);
            if (rxq.size() != 0) check("rx_data", rx_data, rxq[0]);
            check("drop_count", drop_count, exp_drops);
            do_pop = (rxq.size() != 0) && rx_ready;
            do_acc = noc_in_valid && (rxq.size() < D);
`ifdef PE_IF_ADDR_CHECK_EN
            addr_ok = (noc_in_data[FW-1:DW] == AW'(MY));
`else
            addr_ok = 1'b1;
`endif
            if (do_pop) void'(rxq.pop_front());
            if (do_acc && addr_ok) rxq.push_back(noc_in_data[DW-1:0]);
            if (do_acc && !addr_ok && exp_drops < 16'hFFFF) exp_drops++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        tx_data = '0; tx_dest = '0; tx_valid = 1'b0; noc_out_ready = 1'b0;
        noc_in_data = '0; noc_in_valid = 1'b0; rx_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single TX flit
        tx_valid = 1'b1; tx_dest = 3'd5; tx_data = 32'hDEADBEEF; noc_out_ready = 1'b1;
        step();
        tx_valid = 1'b0;
        check("single_valid", noc_out_valid, 1);
        check("single_data", noc_out_data, 35'h5_DEADBEEF);
        step();
        check("single_gone", noc_out_valid, 0);
        repeat (2) step();

        // Fill TX to full with the NoC stalled, then drain
        noc_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'b1; tx_dest = AW'(i); tx_data = 32'hA000_0000 + i;
            step();
        end
        tx_valid = 1'b0;
        check("full_tx_ready", tx_ready, 0);
        repeat (2) step();
        noc_out_ready = 1'b1;
        repeat (6) step();
        check("drained_tx_ready", tx_ready, 1);

        // Streaming: push and pop every cycle
        for (int i = 0; i < 20; i++) begin
            tx_valid = 1'b1; tx_dest = AW'(i); tx_data = 32'h100 + i;
            step();
        end
        tx_valid = 1'b0;
        repeat (3) step();

        // RX flit held while PE stalls, ready toggling
        rx_ready = 1'b0;
        noc_in_valid = 1'b1; noc_in_data = {AW'(MY), 32'h12345678};
        step();
        noc_in_valid = 1'b0;
        check("rx_single_data", rx_data, 32'h12345678);
        for (int i = 0; i < 6; i++) begin
            rx_ready = i[0];
            step();
        end
        check("rx_single_once", rx_valid, 0);

        // Address field: MY, 3, MY
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            noc_in_valid = 1'b1;
            noc_in_data  = {(i == 1) ? AW'(3) : AW'(MY), 32'hC000_0000 + i};
            step();
        end
        noc_in_valid = 1'b0;
        repeat (3) step();

        // Random traffic on both paths
        for (int i = 0; i < 400; i++) begin
            tx_valid      = ($urandom_range(0, 3) != 0);
            tx_dest       = AW'($urandom);
            tx_data       = $urandom;
            noc_out_ready = ($urandom_range(0, 2) != 0);
            noc_in_valid  = ($urandom_range(0, 3) != 0);
            noc_in_data   = {($urandom_range(0, 3) != 0) ? AW'(MY) : AW'($urandom), 32'($urandom)};
            rx_ready      = ($urandom_range(0, 2) != 0);
            step();
        end

        // Reset mid-burst with entries queued in both FIFOs
        noc_out_ready = 1'b0; rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_dest = AW'(i); tx_data = 32'hB000_0000 + i;
            noc_in_valid = 1'b1; noc_in_data = {AW'(MY), 32'hE000_0000 + i};
            step();
        end
        tx_valid = 1'b0; noc_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_noc_valid", noc_out_valid, 0);
        check("async_tx_ready", tx_ready, 1);
        check("async_rx_valid", rx_valid, 0);
        check("async_noc_ready", noc_in_ready, 1);
        step();
        rst_n = 1'b1;
        noc_out_ready = 1'b1; rx_ready = 1'b1;
        repeat (4) step();
        check("post_rst_noc_valid", noc_out_valid, 0);
        check("post_rst_rx_valid", rx_valid, 0);

        // Final drain, bounded
        tx_valid = 1'b0; noc_in_valid = 1'b0; noc_out_ready = 1'b1; rx_ready = 1'b1;
        for (int i = 0; i < 20 && (txq.size() != 0 || rxq.size() != 0); i++) step();
        check("drain_tx_empty", txq.size(), 0);
        check("drain_rx_empty", rxq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_net_if.md
# pe_net_if

PE-side network interface that sits between one processing element and one PE port of the 8-PE H-tree NoC. On the transmit side it accepts payload plus destination from the PE, buffers it, and emits `{dest, data}` flits into the NoC PE input port. On the receive side it buffers flits leaving the NoC PE output port and delivers the stripped payload to the PE. Each path is a first-word-fall-through FIFO with valid/ready handshakes on both faces.

## Interface
- `DataWidth`, 32, PE payload width.
- `AddrWidth`, 3, PE address width; flit width is DataWidth+AddrWidth.
- `MyAddr`, 0, address of the attached PE.
- `FifoDepth`, 4, entries per FIFO; power of two, ≥2.

Ports:
- `i_sclk`  in  1  clock.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_tx_data`  in  DataWidth  PE payload to send.
- `i_tx_dest`  in  AddrWidth  destination PE address.
- `i_tx_valid`  in  1  PE transmit request.
- `o_tx_ready`  out  1  TX FIFO not full.
- `o_noc_data`  out  DataWidth+AddrWidth  flit to NoC: `[DataWidth+AddrWidth-1:DataWidth]` = dest, `[DataWidth-1:0]` = payload.
- `o_noc_valid`  out  1  TX FIFO not empty.
- `i_noc_ready`  in  1  NoC accepts flit.
- `i_noc_data`  in  DataWidth+AddrWidth  flit from NoC.
- `i_noc_valid`  in  1  NoC flit valid.
- `o_noc_ready`  out  1  RX FIFO not full.
- `o_rx_data`  out  DataWidth  delivered payload.
- `o_rx_valid`  out  1  RX FIFO not empty.
- `i_rx_ready`  in  1  PE accepts payload.
- `o_drop_count`  out  16  misrouted flits dropped (see Configuration).

## Operation
- Transfer on any face occurs on the rising `i_sclk` edge where valid && ready.
- TX: on a transfer, push `{i_tx_dest, i_tx_data}`. On an `o_noc` transfer, pop the head. `o_noc_data` always shows the head; it holds stable while `o_noc_valid` is high and `i_noc_ready` is low.
- RX: on an `i_noc` transfer, push the flit. `o_rx_data` = head`[DataWidth-1:0]`. On an `o_rx` transfer, pop the head.
- Each FIFO has read/write pointers one bit wider than log2(FifoDepth). Pointers wrap modulo 2·FifoDepth. Empty when the pointers are equal; full when the MSBs differ and the low bits are equal. Occupancy never exceeds FifoDepth.
- Ready is derived only from full; there is no bypass. When a FIFO is full, push is refused even if a pop occurs in the same cycle. Simultaneous push and pop when not full and not empty leave occupancy unchanged.
- Valid is derived only from empty; a flit is never visible in the cycle it is written.
- Self-addressed TX (`i_tx_dest == MyAddr`) is sent to the NoC unchanged.
- Reset (async assert, sync release) clears all pointers and `o_drop_count`. Any contents in flight are discarded.

## Timing
- Reset values: `o_tx_ready`=1, `o_noc_valid`=0, `o_noc_ready`=1, `o_rx_valid`=0, `o_drop_count`=0. Data outputs are don't-care, but are zero in this implementation.
- Latency is one cycle per path: a push at edge N raises the output valid after edge N.
- Full throughput is one flit per cycle per path, independent of the other path.
- All outputs are registers or are decoded directly from registered pointers. There is no combinational path from `i_*_ready` or `i_*_valid` to any output.

## Configuration
- Macro: `PE_IF_ADDR_CHECK_EN`.
- Defined:
  - An RX flit whose `[DataWidth+AddrWidth-1:DataWidth]` ≠ MyAddr is accepted (`o_noc_ready` follows full as normal) but is not pushed.
  - `o_drop_count` increments, saturating at 16'hFFFF.
- Undefined:
  - All RX flits are pushed and the address field is ignored.
  - `o_drop_count` is tied to 0.

## Test plan
- Single TX, dest=5, data=32'hDEADBEEF, `i_noc_ready`=1 → `o_noc_valid` high one cycle later with `o_noc_data`=35'h5_DEADBEEF, then low.
- Hold `i_noc_ready`=0 and push 4 flits → `o_tx_ready` falls after the 4th push; a 5th push is refused; draining then yields the 4 flits in order and `o_tx_ready` returns to 1.
- Push and pop TX every cycle for 20 cycles with incrementing data → 20 flits out in order, no gaps after the first, pointer wrap exercised.
- RX flit `{MyAddr, 32'h12345678}` with `i_rx_ready` toggling → `o_rx_data`=32'h12345678, stable while stalled, delivered exactly once.
- With `PE_IF_ADDR_CHECK_EN`, MyAddr=2: send flits with addr 2, 3, 2 → two payloads delivered, `o_drop_count`=1.
- Assert `i_reset` low mid-burst with 3 entries queued → all valids go 0 and readies go 1 immediately; after release, no stale flit appears.
